// File: rtl/rr_arb8.sv
// Eight-way round-robin arbiter with a registered one-hot grant, a hold-time limit
// and a one-cycle timeout pulse when the limit revokes a grant.
module rr_arb8 #(
    parameter int MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    input  logic       rel,
    output logic [7:0] gnt,
    output logic       gnt_valid,
    output logic       timeout
);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam logic       HOLD_EN   = (MAX_HOLD != 0);
    localparam logic [7:0] HOLD_LAST = HOLD_EN ? 8'(MAX_HOLD - 1) : 8'd0;

    state_t     state_r, state_s;
    logic [2:0] ptr_r, ptr_s;
    logic [2:0] own_r, own_s;
    logic [7:0] cnt_r, cnt_s;
    logic [7:0] gnt_s;
    logic       timeout_s;
    logic [2:0] sel_s;
    logic       hold_hit_s;
    logic       end_s;

    // First set request bit scanning upward from p, wrapping modulo 8.
    function automatic logic [2:0] rr_pick(input logic [7:0] r, input logic [2:0] p);
        logic [2:0] pick;
        logic [2:0] idx;
        pick = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            idx = p + 3'(i);
            if (r[idx]) begin
                pick = idx;
            end else begin
                pick = pick;
            end
        end
        return pick;
    endfunction

    assign sel_s      = rr_pick(req, ptr_r);
    assign hold_hit_s = HOLD_EN && (cnt_r == HOLD_LAST);
    assign end_s      = rel || !req[own_r] || hold_hit_s;

    // Next-state, pointer, owner, hold counter and next registered outputs.
    always_comb begin
        state_s   = state_r;
        ptr_s     = ptr_r;
        own_s     = own_r;
        cnt_s     = cnt_r;
        gnt_s     = 8'h00;
        timeout_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (req != 8'h00) begin
                    own_s   = sel_s;
                    gnt_s   = 8'h01 << sel_s;
                    cnt_s   = 8'd0;
                    state_s = GRANT;
                end else begin
                    state_s = IDLE;
                end
            end
            GRANT: begin
                if (end_s) begin
                    state_s   = IDLE;
                    ptr_s     = own_r + 3'd1;
                    cnt_s     = 8'd0;
                    // Only a limit-only end is reported as a timeout.
                    timeout_s = !rel && req[own_r];
                end else begin
                    gnt_s = 8'h01 << own_r;
                    cnt_s = (cnt_r == 8'hFF) ? 8'hFF : cnt_r + 8'd1;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State and output registers; reset clears grants immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= IDLE;
            ptr_r     <= 3'd0;
            own_r     <= 3'd0;
            cnt_r     <= 8'd0;
            gnt       <= 8'h00;
            gnt_valid <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            state_r   <= state_s;
            ptr_r     <= ptr_s;
            own_r     <= own_s;
            cnt_r     <= cnt_s;
            gnt       <= gnt_s;
            gnt_valid <= |gnt_s;
            timeout   <= timeout_s;
        end
    end

endmodule

// File: tb/tb_rr_arb8.sv
// Directed self-checking bench for rr_arb8 built with a hold limit of 4 cycles.
module tb_rr_arb8;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] req;
    logic       rel;
    logic [7:0] gnt;
    logic       gnt_valid;
    logic       timeout;

    int n_tests = 0;
    int n_fail  = 0;

    rr_arb8 #(.MAX_HOLD(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .rel       (rel),
        .gnt       (gnt),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Model of the downstream 8-to-3 encoder.
    function automatic logic [2:0] enc8(input logic [7:0] g);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (g[i]) idx = 3'(i);
        end
        return idx;
    endfunction

    task automatic chk_grant(input string tag, input logic [7:0] exp);
        check(tag, {24'd0, gnt}, {24'd0, exp});
        check({tag, "_valid"}, {31'd0, gnt_valid}, {31'd0, (exp != 8'h00)});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with all requesters active
        rst = 1'b1;
        req = 8'hFF;
        rel = 1'b0;
        tick();
        tick();
        chk_grant("rst_gnt", 8'h00);
        check("rst_timeout", {31'd0, timeout}, 32'd0);
        rst = 1'b0;
        tick();
        chk_grant("first_gnt", 8'h01);
        check("first_enc", {29'd0, enc8(gnt)}, 32'd0);

        // Rotation through all eight requesters and back to 0
        for (int i = 1; i <= 8; i++) begin
            rel = 1'b1;
            tick();
            chk_grant("rot_gap", 8'h00);
            rel = 1'b0;
            tick();
            chk_grant("rot_gnt", 8'h01 << (i % 8));
            check("rot_enc", {29'd0, enc8(gnt)}, i % 8);
        end
        req = 8'h00;
        tick();
        tick();
        chk_grant("idle_none", 8'h00);

        // Fairness skip over idle requesters
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req = 8'b1000_0010;
        tick();
        chk_grant("fair_1", 8'h02);
        rel = 1'b1;
        tick();
        rel = 1'b0;
        tick();
        chk_grant("fair_2", 8'h80);
        rel = 1'b1;
        tick();
        rel = 1'b0;
        tick();
        chk_grant("fair_3", 8'h02);

        // Hold limit: four grant cycles then a timeout gap
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req = 8'h08;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk_grant("to_hold", 8'h08);
            check("to_hold_pulse", {31'd0, timeout}, 32'd0);
        end
        tick();
        chk_grant("to_gap", 8'h00);
        check("to_pulse", {31'd0, timeout}, 32'd1);
        tick();
        chk_grant("to_regrant", 8'h08);
        check("to_pulse_end", {31'd0, timeout}, 32'd0);

        // Owner 5 drops its request; priority moves to bit 6
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req = 8'h20;
        tick();
        chk_grant("drop_gnt", 8'h20);
        req = 8'b0100_0001;
        tick();
        chk_grant("drop_gap", 8'h00);
        check("drop_timeout", {31'd0, timeout}, 32'd0);
        tick();
        chk_grant("drop_next", 8'h40);

        // Release coinciding with the hold limit is not a timeout
        tick();
        tick();
        tick();
        chk_grant("coin_hold4", 8'h40);
        rel = 1'b1;
        tick();
        rel = 1'b0;
        chk_grant("coin_gap", 8'h00);
        check("coin_timeout", {31'd0, timeout}, 32'd0);
        tick();
        chk_grant("coin_next", 8'h01);

        // Asynchronous reset in the middle of a grant to requester 6
        rel = 1'b1;
        tick();
        rel = 1'b0;
        tick();
        chk_grant("ar_gnt", 8'h40);
        #2;
        rst = 1'b1;
        #1;
        chk_grant("ar_drop", 8'h00);
        tick();
        rst = 1'b0;
        req = 8'h41;
        tick();
        chk_grant("ar_restart", 8'h01);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/rr_arb8.md
# rr_arb8

Eight-way round-robin arbiter producing a registered one-hot grant vector. It sits directly upstream of the 8-to-3 one-hot encoder. `gnt[7:0]` drives the encoder's `in[7:0]`, and the encoder turns the grant into a 3-bit owner index. The arbiter guarantees that `gnt` is either all-zero or exactly one-hot, so the encoder's input contract always holds. It holds each grant until the owner releases, drops its request, or hits a hold timeout.

## Interface
- `MAX_HOLD`, default 16: maximum grant length in cycles.
  - Legal range is 0..255.
  - 0 disables the timeout.

Ports (clock and reset first):
- `clk`  in  1  single clock. All state changes on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req`  in  8  request vector. Bit i is requester i, level-sensitive.
- `release`  in  1  current owner finished. Sampled only in GRANT.
- `gnt`  out  8  registered grant. Either all-zero or exactly one bit set.
- `gnt_valid`  out  1  registered. Equals `|gnt` in every cycle.
- `timeout`  out  1  registered 1-cycle pulse. Asserted in the cycle after a grant is revoked by the hold limit.

## Operation
Internal state:
- State register: IDLE or GRANT.
- Priority pointer `ptr[2:0]`.
- Owner register `own[2:0]`.
- Hold counter `cnt[7:0]`.

Reset (asynchronous, immediate while `rst`=1):
- State = IDLE, `ptr` = 0, `own` = 0, `cnt` = 0.
- `gnt` = 8'h00, `gnt_valid` = 0, `timeout` = 0.

IDLE:
- `gnt` = 0.
- If `req` == 0, stay in IDLE.
- Otherwise, select the first set bit scanning `ptr`, `ptr`+1, …, `ptr`+7 (mod 8).
- Next edge: `own` = the selected bit, `gnt` = 1<<`own`, `cnt` = 0, state = GRANT.

GRANT:
- `gnt` holds `1<<own` unchanged. Changes on other `req` bits are ignored.
- `cnt` increments each cycle and saturates at 255.
- The grant ends at the edge where any of these is true:
  - (a) `release` = 1,
  - (b) `req[own]` = 0,
  - (c) `MAX_HOLD` != 0 and `cnt` == `MAX_HOLD`-1.
- On end: state = IDLE, `gnt` = 0, `ptr` = (`own`+1) mod 8.
- `timeout` = 1 for one cycle only when (c) alone caused the end, i.e. (a) and (b) were both false.
- If (a) or (b) coincides with (c), the end counts as a normal release and `timeout` stays 0.

Pointer rules:
- `ptr` changes only at grant end, never in IDLE.
- An owner that just finished has the lowest priority in the next arbitration.
- 3-bit arithmetic wraps: owner 7 → `ptr` 0.

`release` in IDLE is ignored. The `req` bits feeding the arbiter are synchronous to `clk`; synchronisation is the requester's responsibility.

## Timing
- Arbitration latency: `req` visible at edge k while in IDLE → `gnt` valid after edge k (1 cycle).
- Minimum grant length is 1 cycle. With `release` held high, the grant lasts exactly 1 cycle.
- Timeout grant length: exactly `MAX_HOLD` cycles of `gnt` asserted.
- Mandatory gap: after a grant ends, `gnt` = 0 for at least one full cycle. The next grant appears at the earliest 2 edges after the end condition was sampled. There are no back-to-back grants.
- `timeout` coincides with the first gap cycle.
- Reset mid-grant: `gnt` and `gnt_valid` drop immediately (asynchronously). After `rst` is deasserted, arbitration restarts from `ptr` = 0.
- Downstream encoder output is combinational from `gnt`, so the owner index is valid in the same cycle as `gnt_valid`.

## Test plan
- **Reset:** assert `rst` with `req` = 8'hFF.
  - Required: `gnt` = 0, `gnt_valid` = 0, `timeout` = 0 while reset is high.
  - After release, with `req` = 8'hFF: first `gnt` = 8'h01 one cycle later.
- **Round-robin rotation:** `req` = 8'hFF held, `release` pulsed 1 cycle after each grant.
  - Required grant sequence: 8'h01, 8'h02, 8'h04 … 8'h80, 8'h01.
  - Exactly one zero cycle between consecutive grants.
  - Encoder output 0..7, then 0.
- **Fairness skip:** `req` = 8'b1000_0010, `ptr` = 0 after reset.
  - Grant 8'h02, then after release 8'h80, then 8'h02.
  - Bits 2..6 are never granted.
- **Timeout:** `MAX_HOLD` = 4, `req` = 8'h08 held, `release` = 0.
  - `gnt` = 8'h08 for exactly 4 cycles.
  - Then `gnt` = 0 with `timeout` = 1 for one cycle.
  - Then `gnt` = 8'h08 again.
- **Request drop and coincidence:**
  - Owner bit 5 deasserts `req[5]` mid-grant → `gnt` = 0 next cycle, `timeout` = 0, next priority starts at bit 6.
  - With `MAX_HOLD` = 4, assert `release` on hold cycle 4 → `timeout` stays 0.
- **Async reset mid-grant:** assert `rst` between edges during `gnt` = 8'h40.
  - `gnt` = 0 before the next edge.
  - After reset with `req` = 8'h41: grant 8'h01 first.
